// File: rtl/fmac_rx_port_arbiter_if.sv
// fmac_rx_port_arbiter_if: per-port request/write signals and shared bridge FIFO signals of the RX port arbiter
interface fmac_rx_port_arbiter_if #(
    parameter int NPORT = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BCNT_WIDTH = 32
);
    localparam int PW = $clog2(NPORT);
    logic [NPORT-1:0] port_req;
    logic [NPORT-1:0] port_done;
    logic [NPORT-1:0] port_wren_rf;
    logic [NPORT*DATA_WIDTH-1:0] port_datain_rf;
    logic [NPORT-1:0] port_wren_rcf;
    logic [NPORT*BCNT_WIDTH-1:0] port_datain_rcf;
    logic wrempty_rf;
    logic wrempty_rcf;
    logic [NPORT-1:0] port_gnt;
    logic wren_rf;
    logic [DATA_WIDTH-1:0] datain_rf;
    logic wren_rcf;
    logic [BCNT_WIDTH-1:0] datain_rcf;
    logic wdog_err;
    logic [PW-1:0] wdog_port;
    modport slave (
        input port_req, port_done, port_wren_rf, port_datain_rf, port_wren_rcf, port_datain_rcf,
        input wrempty_rf, wrempty_rcf,
        output port_gnt, wren_rf, datain_rf, wren_rcf, datain_rcf, wdog_err, wdog_port
    );
    modport master (
        output port_req, port_done, port_wren_rf, port_datain_rf, port_wren_rcf, port_datain_rcf,
        output wrempty_rf, wrempty_rcf,
        input port_gnt, wren_rf, datain_rf, wren_rcf, datain_rcf, wdog_err, wdog_port
    );
endinterface

// File: rtl/fmac_rx_port_arbiter.sv
// fmac_rx_port_arbiter: packet-granular round-robin arbiter muxing RX ports onto shared bridge FIFOs
module fmac_rx_port_arbiter #(
    parameter int NPORT = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BCNT_WIDTH = 32,
    parameter int WDOG_WIDTH = 16,
    parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = 16'hFFFF
) (
    input logic clk_fib,
    input logic reset,
    fmac_rx_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NPORT);
    localparam logic [PW:0] NP = (PW+1)'(NPORT);
    typedef enum logic [2:0] {ARB_IDLE = 3'b001, ARB_GRANT = 3'b010, ARB_DONE = 3'b100} state_t;
    state_t state, nxt;
    logic [PW-1:0] cur, ptr, win, cur_d, cur_inc;
    logic [WDOG_WIDTH-1:0] wdog, wdog_d;
    logic [NPORT-1:0] gnt_d;
    logic req_ok, done_cur, wdog_hit, abort, take_rf, take_rcf;
    assign req_ok = (|bus.port_req) & bus.wrempty_rf & bus.wrempty_rcf;
    assign done_cur = bus.port_done[cur];
    assign wdog_hit = wdog == WDOG_LIMIT;
    assign cur_inc = cur == PW'(NPORT-1) ? '0 : cur + 1'b1;
    // round-robin scan: the requester closest at or after ptr wins
    always_comb begin
        logic [PW:0] s;
        s = '0;
        win = ptr;
        for (int i = NPORT - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (PW+1)'(i);
            s = s >= NP ? s - NP : s;
            win = bus.port_req[s[PW-1:0]] ? s[PW-1:0] : win;
        end
    end
    // next-state: done and watchdog expiry both end the grant
    always_comb begin
        nxt = state == ARB_IDLE ? (req_ok ? ARB_GRANT : ARB_IDLE) :
              state == ARB_GRANT ? ((done_cur | wdog_hit) ? ARB_DONE : ARB_GRANT) : ARB_IDLE;
    end
    // next values of the registered outputs and arbitration bookkeeping
    always_comb begin
        cur_d = (state == ARB_IDLE && req_ok) ? win : cur;
        gnt_d = nxt == ARB_GRANT ? NPORT'(1) << cur_d : '0;
        wdog_d = state == ARB_IDLE ? '0 : (state == ARB_GRANT && !wdog_hit) ? wdog + 1'b1 : wdog;
        abort = state == ARB_GRANT && wdog_hit && !done_cur;
        take_rf = state == ARB_GRANT && bus.port_wren_rf[cur];
        take_rcf = state == ARB_GRANT && bus.port_wren_rcf[cur];
    end
    // state register
    always_ff @(posedge clk_fib or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else state <= nxt;
    end
    // winner, pointer, watchdog and registered FIFO-side outputs
    always_ff @(posedge clk_fib or posedge reset) begin
        if (reset) begin
            cur <= '0;
            ptr <= '0;
            wdog <= '0;
            bus.port_gnt <= '0;
            bus.wren_rf <= 1'b0;
            bus.datain_rf <= '0;
            bus.wren_rcf <= 1'b0;
            bus.datain_rcf <= '0;
            bus.wdog_err <= 1'b0;
            bus.wdog_port <= '0;
        end else begin
            cur <= cur_d;
            ptr <= state == ARB_DONE ? cur_inc : ptr;
            wdog <= wdog_d;
            bus.port_gnt <= gnt_d;
            bus.wren_rf <= take_rf;
            bus.wren_rcf <= take_rcf;
            if (take_rf) bus.datain_rf <= bus.port_datain_rf[cur*DATA_WIDTH +: DATA_WIDTH];
            if (take_rcf) bus.datain_rcf <= bus.port_datain_rcf[cur*BCNT_WIDTH +: BCNT_WIDTH];
            if (abort) begin
                bus.wdog_err <= 1'b1;
                bus.wdog_port <= cur;
            end
        end
    end
endmodule

// File: tb/tb_fmac_rx_port_arbiter.sv
// tb_fmac_rx_port_arbiter: randomized scoreboard bench for the RX port arbiter
module tb_fmac_rx_port_arbiter;
    localparam int NPORT = 4;
    localparam int DW = 64;
    localparam int BW = 32;
    localparam int NPKT = 40;
    localparam logic [15:0] LIM = 16'd20;
    typedef struct {logic [63:0] d; int c;} wr_t;
    typedef struct {bit rise; int port; int c; bit err; int wport;} ge_t;
    logic clk_fib = 1'b0;
    logic reset = 1'b1;
    wr_t rf_q[$];
    wr_t rcf_q[$];
    ge_t g_q[$];
    wr_t mw;
    ge_t mg;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int e_cyc = 0;
    bit mon_en = 1'b0;
    logic [3:0] prev_gnt = '0;

    always #5 clk_fib = ~clk_fib;

    fmac_rx_port_arbiter_if #(.NPORT(NPORT), .DATA_WIDTH(DW), .BCNT_WIDTH(BW)) bus ();

    fmac_rx_port_arbiter #(
        .NPORT(NPORT), .DATA_WIDTH(DW), .BCNT_WIDTH(BW), .WDOG_WIDTH(16), .WDOG_LIMIT(LIM)
    ) dut (
        .clk_fib(clk_fib),
        .reset(reset),
        .bus(bus)
    );

    always @(posedge clk_fib) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int next_winner(input logic [3:0] pd, input int p);
        for (int k = 0; k < NPORT; k++)
            if (pd[(p + k) % NPORT]) return (p + k) % NPORT;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk_fib);
        #1;
        bus.port_wren_rf = '0;
        bus.port_wren_rcf = '0;
        bus.port_done = '0;
        if (cyc >= e_cyc) begin
            bus.wrempty_rf = 1'b1;
            bus.wrempty_rcf = 1'b1;
        end
    endtask

    task automatic noise(input int p);
        int q;
        if ($urandom_range(0, 2) == 0) begin
            q = (p + 1 + int'($urandom_range(0, 2))) % NPORT;
            bus.port_wren_rf[q] = 1'b1;
            bus.port_datain_rf[q*DW +: DW] = {$urandom, $urandom};
            bus.port_wren_rcf[q] = 1'($urandom_range(0, 1));
            bus.port_datain_rcf[q*BW +: BW] = $urandom;
            bus.port_done[q] = 1'($urandom_range(0, 1));
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a write or a grant edge
    always @(negedge clk_fib) begin
        if (mon_en) begin
            if (bus.wren_rf) begin
                if (rf_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rf_unexpected: got write %0h want none", bus.datain_rf);
                end else begin
                    mw = rf_q.pop_front();
                    chk("rf_data", bus.datain_rf, mw.d);
                    chk("rf_cycle", 64'(cyc), 64'(mw.c));
                end
            end
            if (bus.wren_rcf) begin
                if (rcf_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rcf_unexpected: got write %0h want none", bus.datain_rcf);
                end else begin
                    mw = rcf_q.pop_front();
                    chk("rcf_data", 64'(bus.datain_rcf), mw.d);
                    chk("rcf_cycle", 64'(cyc), 64'(mw.c));
                end
            end
            if (prev_gnt != bus.port_gnt) begin
                if (g_q.size() == 0 || (g_q[0].rise != (prev_gnt == 0))) begin
                    total++; bad++;
                    $display("FAIL gnt_unexpected: got %b after %b at cycle %0d", bus.port_gnt, prev_gnt, cyc);
                end else begin
                    mg = g_q.pop_front();
                    chk(mg.rise ? "gnt_onehot" : "gnt_release", 64'(bus.port_gnt), mg.rise ? 64'(4'b0001 << mg.port) : 64'd0);
                    chk(mg.rise ? "gnt_cycle" : "release_cycle", 64'(cyc), 64'(mg.c));
                    if (!mg.rise) begin
                        chk("wdog_err", 64'(bus.wdog_err), 64'(mg.err));
                        if (mg.err) chk("wdog_port", 64'(bus.wdog_port), 64'(mg.wport));
                    end
                end
            end
            prev_gnt = bus.port_gnt;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [3:0] pend;
        logic [63:0] dv;
        logic [31:0] bc;
        int mptr, exp, g, d, a, nb, mode, s, cnt, wport_m;
        bit err_m, abort_run;
        mptr = 0; err_m = 0; wport_m = 0; abort_run = 0;
        bus.port_req = '0;
        bus.port_done = '0;
        bus.port_wren_rf = '0;
        bus.port_wren_rcf = '0;
        bus.port_datain_rf = '0;
        bus.port_datain_rcf = '0;
        bus.wrempty_rf = 1'b1;
        bus.wrempty_rcf = 1'b1;
        repeat (3) @(posedge clk_fib);
        #1;
        chk("reset_gnt", 64'(bus.port_gnt), 0);
        chk("reset_wren_rf", 64'(bus.wren_rf), 0);
        chk("reset_wren_rcf", 64'(bus.wren_rcf), 0);
        chk("reset_datain_rf", bus.datain_rf, 0);
        chk("reset_wdog_err", 64'(bus.wdog_err), 0);
        chk("reset_wdog_port", 64'(bus.wdog_port), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        e_cyc = cyc;
        d = cyc - 2;
        pend = 4'b1111;
        bus.port_req = pend;
        for (int i = 0; i < NPKT; i++) begin
            exp = next_winner(pend, mptr);
            a = (d + 2) > e_cyc ? d + 2 : e_cyc;
            g_q.push_back('{1'b1, exp, a + 1, 1'b0, 0});
            cnt = 0;
            do begin step(); cnt++; end while (!bus.port_gnt[exp] && cnt < 40);
            if (!bus.port_gnt[exp]) begin
                total++; bad++;
                $display("FAIL grant_timeout: got gnt %b want port %0d", bus.port_gnt, exp);
                abort_run = 1;
                break;
            end
            g = cyc;
            e_cyc = 1 << 30;
            if (i >= 5) begin
                bus.wrempty_rf = 1'($urandom_range(0, 1));
                bus.wrempty_rcf = 1'($urandom_range(0, 1));
            end
            mode = i == 3 ? 2 : i == 7 ? 1 : (i > 8 && $urandom_range(0, 5) == 0) ? 1 + int'($urandom_range(0, 1)) : 0;
            nb = i < 5 ? 1 : i == 5 ? 3 : 1 + int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                if (i > 6 && $urandom_range(0, 1) == 1) begin
                    noise(exp);
                    step();
                end
                dv = {$urandom, $urandom};
                bus.port_wren_rf[exp] = 1'b1;
                bus.port_datain_rf[exp*DW +: DW] = dv;
                rf_q.push_back('{dv, cyc + 1});
                if (i == 6 && b == 0) begin
                    bus.port_wren_rf[3] = 1'b1;
                    bus.port_datain_rf[3*DW +: DW] = 64'hDEAD_BEEF_0000_0003;
                    bus.port_done[3] = 1'b1;
                end else if (i > 6) noise(exp);
                step();
            end
            while (mode != 0 && cyc < g + 20) step();
            d = cyc;
            if (mode != 1) begin
                bc = i == 5 ? 32'h0000_0018 : $urandom;
                bus.port_wren_rcf[exp] = 1'b1;
                bus.port_datain_rcf[exp*BW +: BW] = bc;
                bus.port_done[exp] = 1'b1;
                rcf_q.push_back('{64'(bc), d + 1});
                if (i > 5 && $urandom_range(0, 1) == 1) begin
                    dv = {$urandom, $urandom};
                    bus.port_wren_rf[exp] = 1'b1;
                    bus.port_datain_rf[exp*DW +: DW] = dv;
                    rf_q.push_back('{dv, d + 1});
                end
                if (i > 6) noise(exp);
            end else begin
                err_m = 1;
                wport_m = exp;
            end
            g_q.push_back('{1'b0, exp, d + 1, err_m, wport_m});
            if (i == NPKT - 1) pend = 4'b0000;
            else if (i == 4) pend = 4'b0100;
            else if (i == 5) pend = 4'b0010;
            else if (i == 6) pend = 4'b1100;
            else if (i == 7) pend = 4'b1000;
            else if (i == 8) pend = 4'b0001;
            else if (i > 8) begin
                if ($urandom_range(0, 1) == 1) pend[exp] = 1'b0;
                pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                if (pend == 0) pend[$urandom_range(0, 3)] = 1'b1;
            end
            bus.port_req = pend;
            s = i < 8 ? 0 : i == 8 ? 4 : int'($urandom_range(0, 3));
            if (s == 0) begin
                bus.wrempty_rf = 1'b1;
                bus.wrempty_rcf = 1'b1;
                e_cyc = d;
            end else begin
                bus.wrempty_rf = (i > 8 && $urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
                bus.wrempty_rcf = ~bus.wrempty_rf;
                e_cyc = d + 1 + s;
            end
            mptr = (exp + 1) % NPORT;
        end
        if (!abort_run) begin
            repeat (10) step();
            chk("rf_left", 64'(rf_q.size()), 0);
            chk("rcf_left", 64'(rcf_q.size()), 0);
            chk("gnt_events_left", 64'(g_q.size()), 0);
            mon_en = 1'b0;
            pend = 4'b0001;
            bus.port_req = pend;
            cnt = 0;
            do begin step(); cnt++; end while (!bus.port_gnt[0] && cnt < 40);
            chk("pre_reset_gnt", 64'(bus.port_gnt), 64'(4'b0001));
            bus.port_wren_rf[0] = 1'b1;
            bus.port_wren_rcf[0] = 1'b1;
            bus.port_datain_rf[0 +: DW] = 64'h0123_4567_89AB_CDEF;
            step();
            bus.port_wren_rf[0] = 1'b1;
            chk("pre_reset_wren_rf", 64'(bus.wren_rf), 1);
            chk("pre_reset_wdog_err", 64'(bus.wdog_err), 1);
            #2 reset = 1'b1;
            #1;
            chk("async_gnt", 64'(bus.port_gnt), 0);
            chk("async_wren_rf", 64'(bus.wren_rf), 0);
            chk("async_wren_rcf", 64'(bus.wren_rcf), 0);
            chk("async_wdog_err", 64'(bus.wdog_err), 0);
            chk("async_wdog_port", 64'(bus.wdog_port), 0);
            chk("async_datain_rf", bus.datain_rf, 0);
            bus.port_wren_rf = '0;
            bus.port_wren_rcf = '0;
            @(posedge clk_fib);
            #1;
            reset = 1'b0;
            pend = 4'b1111;
            bus.port_req = pend;
            step();
            chk("restart_gnt", 64'(bus.port_gnt), 64'(4'b0001));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
